int_moderator: RTL and testbench
================================

// Module: int_moderator
// PURPOSE
//  Per-source interrupt moderation (coalescing) placed between user event sources and the
//  interrupt router's int_valid/int_ready interface. Counts raw event pulses per source, raises
//  int_valid when a count threshold or an age timeout is reached, then enforces a holdoff
//  interval after each router acknowledge. Bounds the MSI/legacy interrupt rate without losing events.
// PARAMETERS
//  COUNT   16  number of interrupt sources (1..32)
//  CNT_W    8  width of per-source event counter and threshold
//  TMR_W   16  width of timeout/holdoff counters (units: clk cycles)
// PORTS
//  clk             in   1             clock
//  reset           in   1             synchronous, active-high
//  ev_pulse        in   COUNT         raw event, one event per source per high cycle
//  int_valid       out  COUNT         interrupt request toward router, level
//  int_ready       in   COUNT         router acknowledge, 1-cycle pulse per source
//  cfg_valid       in   1             config write strobe
//  cfg_ready       out  1             constant 1
//  cfg_sel         in   5             source index written
//  cfg_threshold   in   CNT_W         events needed to assert (0 treated as 1)
//  cfg_timeout     in   TMR_W         max age of first pending event (0 = timer disabled)
//  cfg_holdoff     in   TMR_W         min cycles between ack and next assert
//  ev_overflow     out  COUNT         sticky: event counter saturated
//  ovf_clear       in   COUNT         1-cycle clear of ev_overflow bits
// BEHAVIOUR
//  Reset: int_valid=0, ev_overflow=0, counters=0, all states IDLE; per-source cfg: threshold=1,
//   timeout=0, holdoff=0. Reset mid-operation discards all pending events.
//  Config: write when cfg_valid; cfg_sel>=COUNT ignored. New values are used at the next
//   load/compare; a running timer is not reloaded.
//  Per-source FSM, thr = max(threshold,1):
//   IDLE:    ev -> cnt=1; if thr==1 -> ASSERT, else tmr=timeout -> ACCUM.
//   ACCUM:   ev -> cnt+1 (saturating at 2^CNT_W-1, sets ev_overflow); if timeout!=0, tmr-1 each
//            cycle. cnt(next)>=thr or (timeout!=0 and tmr==1) -> ASSERT.
//   ASSERT:  int_valid=1. On int_ready: cnt = ev?1:0 (same-cycle event is new, never lost);
//            tmr=holdoff -> HOLDOFF; if holdoff==0, evaluate HOLDOFF exit in the same cycle.
//   HOLDOFF: int_valid=0; events accumulate as in ACCUM; tmr-1 each cycle. At tmr==0:
//            cnt>=thr -> ASSERT; cnt>0 -> tmr=timeout, ACCUM; else IDLE.
//  Latency: event in cycle N with thr==1 -> int_valid high in N+1. int_ready in N ->
//   int_valid low in N+1.
//  int_ready when not in ASSERT is ignored. ovf_clear and same-cycle saturation: set wins.
//  int_valid depends only on registered state (no combinational path from inputs).
// TESTING
//  1. thr=1, timeout=0, holdoff=0; ev_pulse[3] at N -> int_valid[3]=1 at N+1; int_ready[3]
//     at N+4 -> int_valid[3]=0 at N+5.
//  2. src 0 thr=4, timeout=0; 3 events -> int_valid[0] stays 0; 4th event -> int_valid[0]=1 next cycle.
//  3. src 1 thr=8, timeout=100; one event at N -> int_valid[1]=1 at N+101 (+-0), count 1 pending.
//  4. src 2 thr=1, holdoff=50; ack at N, events at N+5, N+10 -> int_valid[2] low until
//     N+51, high at N+51; event at the ack cycle itself also re-asserts after holdoff.
//  5. CNT_W=8, thr=255, 300 events -> ev_overflow set, int_valid asserted; ovf_clear -> 0.
//  6. Assert reset while int_valid[5]=1 and 3 events pending -> next cycle all outputs 0,
//     no re-assertion without new events; cfg back to defaults.

Source files
------------

// File: rtl/int_moderator.sv
// Per-source interrupt moderation: counts event pulses per source and raises
// int_valid when a count threshold or an age timeout is reached. After each
// router acknowledge it enforces a holdoff interval. Events that arrive during
// holdoff or in the acknowledge cycle are kept, not dropped.
module int_moderator #(
  parameter int unsigned COUNT = 16,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned TMR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COUNT-1:0]   ev_pulse,
  output logic [COUNT-1:0]   int_valid,
  input  logic [COUNT-1:0]   int_ready,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [4:0]         cfg_sel,
  input  logic [CNT_W-1:0]   cfg_threshold,
  input  logic [TMR_W-1:0]   cfg_timeout,
  input  logic [TMR_W-1:0]   cfg_holdoff,
  output logic [COUNT-1:0]   ev_overflow,
  input  logic [COUNT-1:0]   ovf_clear
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_ASSERT  = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t           r_state   [COUNT];
  logic [CNT_W-1:0] r_cnt     [COUNT];
  logic [TMR_W-1:0] r_tmr     [COUNT];
  logic [CNT_W-1:0] r_thr     [COUNT];
  logic [TMR_W-1:0] r_timeout [COUNT];
  logic [TMR_W-1:0] r_holdoff [COUNT];
  logic [COUNT-1:0] r_valid;
  logic [COUNT-1:0] r_ovf;

  state_t           w_state_nxt [COUNT];
  logic [CNT_W-1:0] w_cnt_nxt   [COUNT];
  logic [TMR_W-1:0] w_tmr_nxt   [COUNT];
  logic [CNT_W-1:0] w_thr       [COUNT];
  logic [CNT_W-1:0] w_inc       [COUNT];
  logic [CNT_W-1:0] w_new       [COUNT];
  logic [COUNT-1:0] w_sat;
  logic [COUNT-1:0] w_ovf_set;
  logic [COUNT-1:0] w_valid_nxt;

  assign cfg_ready   = 1'b1;
  assign int_valid   = r_valid;
  assign ev_overflow = r_ovf;

  // Next-state, counter and timer computation for every source.
  // The holdoff-exit decision is evaluated on the count including the current
  // cycle's event, and also directly in the ack cycle when holdoff is zero.
  always_comb begin
    w_sat       = '0;
    w_ovf_set   = '0;
    w_valid_nxt = '0;
    for (int unsigned i = 0; i < COUNT; i++) begin
      w_thr[i]       = (r_thr[i] == '0) ? CNT_W'(1) : r_thr[i];
      w_sat[i]       = (r_cnt[i] == '1);
      w_inc[i]       = (ev_pulse[i] && !w_sat[i]) ? r_cnt[i] + CNT_W'(1) : r_cnt[i];
      w_new[i]       = ev_pulse[i] ? CNT_W'(1) : '0;
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      w_tmr_nxt[i]   = r_tmr[i];
      unique case (r_state[i])
        S_IDLE: begin
          if (ev_pulse[i]) begin
            w_cnt_nxt[i] = CNT_W'(1);
            if (w_thr[i] == CNT_W'(1)) begin
              w_state_nxt[i] = S_ASSERT;
            end else begin
              w_tmr_nxt[i]   = r_timeout[i];
              w_state_nxt[i] = S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          w_cnt_nxt[i] = w_inc[i];
          w_ovf_set[i] = ev_pulse[i] & w_sat[i];
          if (r_timeout[i] != '0 && r_tmr[i] != '0) begin
            w_tmr_nxt[i] = r_tmr[i] - TMR_W'(1);
          end
          if (w_inc[i] >= w_thr[i] ||
              (r_timeout[i] != '0 && r_tmr[i] == TMR_W'(1))) begin
            w_state_nxt[i] = S_ASSERT;
          end
        end
        S_ASSERT: begin
          if (int_ready[i]) begin
            w_cnt_nxt[i] = w_new[i];
            if (r_holdoff[i] == '0) begin
              if (w_new[i] >= w_thr[i]) begin
                w_state_nxt[i] = S_ASSERT;
              end else if (w_new[i] != '0) begin
                w_tmr_nxt[i]   = r_timeout[i];
                w_state_nxt[i] = S_ACCUM;
              end else begin
                w_state_nxt[i] = S_IDLE;
              end
            end else begin
              w_tmr_nxt[i]   = r_holdoff[i];
              w_state_nxt[i] = S_HOLDOFF;
            end
          end else begin
            w_cnt_nxt[i] = w_inc[i];
            w_ovf_set[i] = ev_pulse[i] & w_sat[i];
          end
        end
        S_HOLDOFF: begin
          w_cnt_nxt[i] = w_inc[i];
          w_ovf_set[i] = ev_pulse[i] & w_sat[i];
          if (r_tmr[i] <= TMR_W'(1)) begin
            w_tmr_nxt[i] = '0;
            if (w_inc[i] >= w_thr[i]) begin
              w_state_nxt[i] = S_ASSERT;
            end else if (w_inc[i] != '0) begin
              w_tmr_nxt[i]   = r_timeout[i];
              w_state_nxt[i] = S_ACCUM;
            end else begin
              w_state_nxt[i] = S_IDLE;
            end
          end else begin
            w_tmr_nxt[i] = r_tmr[i] - TMR_W'(1);
          end
        end
        default: w_state_nxt[i] = S_IDLE;
      endcase
      w_valid_nxt[i] = (w_state_nxt[i] == S_ASSERT);
    end
  end

  // State, counters, configuration and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_ovf   <= '0;
      for (int unsigned i = 0; i < COUNT; i++) begin
        r_state[i]   <= S_IDLE;
        r_cnt[i]     <= '0;
        r_tmr[i]     <= '0;
        r_thr[i]     <= CNT_W'(1);
        r_timeout[i] <= '0;
        r_holdoff[i] <= '0;
      end
    end else begin
      r_valid <= w_valid_nxt;
      r_ovf   <= (r_ovf & ~ovf_clear) | w_ovf_set;
      for (int unsigned i = 0; i < COUNT; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
        r_tmr[i]   <= w_tmr_nxt[i];
        if (cfg_valid && (32'(cfg_sel) == i)) begin
          r_thr[i]     <= cfg_threshold;
          r_timeout[i] <= cfg_timeout;
          r_holdoff[i] <= cfg_holdoff;
        end
      end
    end
  end

endmodule

// File: tb/tb_int_moderator.sv
// Self-checking bench for int_moderator: directed stimulus pushes timed
// expectations into a scoreboard queue; a monitor checks them on the
// falling edge of the cycle they name.
module tb_int_moderator;

  localparam int unsigned NS = 16;

  logic            clk;
  logic            reset;
  logic [NS-1:0]   ev_pulse;
  logic [NS-1:0]   int_valid;
  logic [NS-1:0]   int_ready;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [4:0]      cfg_sel;
  logic [7:0]      cfg_threshold;
  logic [15:0]     cfg_timeout;
  logic [15:0]     cfg_holdoff;
  logic [NS-1:0]   ev_overflow;
  logic [NS-1:0]   ovf_clear;

  int_moderator #(.COUNT(16), .CNT_W(8), .TMR_W(16)) dut (
    .clk(clk), .reset(reset), .ev_pulse(ev_pulse), .int_valid(int_valid),
    .int_ready(int_ready), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_threshold(cfg_threshold), .cfg_timeout(cfg_timeout),
    .cfg_holdoff(cfg_holdoff), .ev_overflow(ev_overflow), .ovf_clear(ovf_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = int_valid bit, 1 = ev_overflow bit, 2 = int_valid vector, 3 = ev_overflow vector
  typedef struct {
    int unsigned cyc;
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] val;
  } sb_t;

  sb_t         sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: check every expectation due in the current cycle.
  always @(negedge clk) begin
    logic [31:0] obs;
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          0:       obs = {31'd0, int_valid[sb[i].idx]};
          1:       obs = {31'd0, ev_overflow[sb[i].idx]};
          2:       obs = {16'd0, int_valid};
          default: obs = {16'd0, ev_overflow};
        endcase
        chk_eq(sb[i].tag, obs, sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic exp_at(input string tag, input int unsigned d, input int kind,
                        input int idx, input logic [31:0] val);
    sb_t e;
    e.cyc  = cyc + d;
    e.tag  = tag;
    e.kind = kind;
    e.idx  = idx;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [NS-1:0] e, input logic [NS-1:0] r, input logic [NS-1:0] c);
    ev_pulse  = e;
    int_ready = r;
    ovf_clear = c;
    tick();
    ev_pulse  = '0;
    int_ready = '0;
    ovf_clear = '0;
  endtask

  task automatic cfg_wr(input logic [4:0] sel, input logic [7:0] thr,
                        input logic [15:0] to, input logic [15:0] ho);
    cfg_valid     = 1'b1;
    cfg_sel       = sel;
    cfg_threshold = thr;
    cfg_timeout   = to;
    cfg_holdoff   = ho;
    tick();
    cfg_valid = 1'b0;
  endtask

  function automatic logic [NS-1:0] b(input int i);
    logic [NS-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    reset = 1'b1; ev_pulse = '0; int_ready = '0; ovf_clear = '0;
    cfg_valid = 1'b0; cfg_sel = '0; cfg_threshold = '0; cfg_timeout = '0; cfg_holdoff = '0;
    idle(3);
    reset = 1'b0;
    exp_at("rst_valid", 0, 2, 0, 0);
    exp_at("rst_ovf",   0, 3, 0, 0);
    exp_at("rst_valid_hold", 1, 2, 0, 0);
    chk_eq("cfg_ready", {31'd0, cfg_ready}, 32'd1);
    idle(2);

    // Test 1: defaults, thr=1 on source 3
    exp_at("t1_pre",   0, 0, 3, 0);
    exp_at("t1_rise",  1, 0, 3, 1);
    exp_at("t1_held",  4, 0, 3, 1);
    exp_at("t1_fall",  5, 0, 3, 0);
    pulse(b(3), '0, '0);
    idle(3);
    pulse('0, b(3), '0);
    idle(1);
    exp_at("t1_stray_ack", 1, 0, 3, 0);
    pulse('0, b(3), '0);
    exp_at("t1_rearm", 1, 0, 3, 1);
    pulse(b(3), '0, '0);
    exp_at("t1_rearm_fall", 1, 0, 3, 0);
    pulse('0, b(3), '0);
    idle(2);

    // Test 2: source 0 threshold 4
    cfg_wr(5'd0, 8'd4, 16'd0, 16'd0);
    exp_at("t2_ev1", 1, 0, 0, 0);
    exp_at("t2_ev3", 3, 0, 0, 0);
    exp_at("t2_wait", 5, 0, 0, 0);
    exp_at("t2_ev4", 6, 0, 0, 1);
    exp_at("t2_ack", 8, 0, 0, 0);
    pulse(b(0), '0, '0);
    pulse(b(0), '0, '0);
    pulse(b(0), '0, '0);
    idle(2);
    pulse(b(0), '0, '0);
    idle(1);
    pulse('0, b(0), '0);
    idle(2);

    // Test 3: source 1 threshold 8, timeout 100
    cfg_wr(5'd1, 8'd8, 16'd100, 16'd0);
    exp_at("t3_early", 100, 0, 1, 0);
    exp_at("t3_timeout", 101, 0, 1, 1);
    pulse(b(1), '0, '0);
    idle(100);
    exp_at("t3_ack", 1, 0, 1, 0);
    pulse('0, b(1), '0);
    idle(2);

    // Test 4: source 2 threshold 1, holdoff 50
    cfg_wr(5'd2, 8'd1, 16'd0, 16'd50);
    exp_at("t4_first", 1, 0, 2, 1);
    pulse(b(2), '0, '0);
    exp_at("t4_ho_start", 1, 0, 2, 0);
    exp_at("t4_ho_last", 50, 0, 2, 0);
    exp_at("t4_ho_exit", 51, 0, 2, 1);
    pulse('0, b(2), '0);
    idle(4);
    pulse(b(2), '0, '0);
    idle(4);
    pulse(b(2), '0, '0);
    idle(40);
    exp_at("t4_ackev_start", 1, 0, 2, 0);
    exp_at("t4_ackev_last", 50, 0, 2, 0);
    exp_at("t4_ackev_exit", 51, 0, 2, 1);
    pulse(b(2), b(2), '0);
    idle(50);
    exp_at("t4_empty_ho", 51, 0, 2, 0);
    exp_at("t4_empty_idle", 60, 0, 2, 0);
    pulse('0, b(2), '0);
    idle(61);

    // Test 5: source 4 threshold 255, saturation and overflow
    cfg_wr(5'd4, 8'd255, 16'd0, 16'd0);
    exp_at("t5_below", 254, 0, 4, 0);
    exp_at("t5_reach", 255, 0, 4, 1);
    exp_at("t5_ovf_pre", 255, 1, 4, 0);
    exp_at("t5_ovf_set", 256, 1, 4, 1);
    for (int k = 0; k < 300; k++) pulse(b(4), '0, '0);
    exp_at("t5_ovf_clear", 1, 1, 4, 0);
    exp_at("t5_valid_kept", 1, 0, 4, 1);
    pulse('0, '0, b(4));
    idle(1);
    exp_at("t5_set_wins", 1, 1, 4, 1);
    pulse(b(4), '0, b(4));
    exp_at("t5_clear2", 1, 1, 4, 0);
    pulse('0, '0, b(4));
    exp_at("t5_ack", 1, 0, 4, 0);
    pulse('0, b(4), '0);
    idle(2);

    // Test 6: reset while source 5 asserted with pending events
    cfg_wr(5'd5, 8'd2, 16'd0, 16'd0);
    cfg_wr(5'd6, 8'd3, 16'd0, 16'd0);
    exp_at("t6_assert", 2, 0, 5, 1);
    exp_at("t6_pending", 5, 0, 5, 1);
    pulse(b(5) | b(6), '0, '0);
    pulse(b(5), '0, '0);
    pulse(b(5), '0, '0);
    pulse(b(5), '0, '0);
    pulse(b(5), '0, '0);
    exp_at("t6_rst_valid", 1, 2, 0, 0);
    exp_at("t6_rst_ovf", 1, 3, 0, 0);
    exp_at("t6_no_reassert", 10, 2, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(10);
    exp_at("t6_dflt_thr5", 1, 0, 5, 1);
    exp_at("t6_dflt_thr1", 1, 0, 1, 1);
    pulse(b(5) | b(1), '0, '0);
    cfg_wr(5'd16, 8'd5, 16'd0, 16'd0);
    exp_at("t6_acked", 1, 2, 0, 0);
    pulse('0, b(5) | b(1), '0);
    exp_at("t6_sel_oob", 1, 0, 0, 1);
    pulse(b(0), '0, '0);
    exp_at("t6_src0_ack", 1, 0, 0, 0);
    pulse('0, b(0), '0);
    exp_at("t6_ho0_first", 1, 0, 2, 1);
    pulse(b(2), '0, '0);
    exp_at("t6_ho0_reassert", 1, 0, 2, 1);
    pulse(b(2), b(2), '0);
    exp_at("t6_ho0_fall", 1, 0, 2, 0);
    pulse('0, b(2), '0);
    idle(3);

    chk_eq("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
